pc_branch_seq: RTL and testbench

//   Program-counter sequencer. Consumes the taken/not-taken result of the branch

---
 rtl/pc_branch_seq.sv | 109 ++++++++++
 tb/tb_pc_branch_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_seq.sv
// pc_branch_seq: program-counter sequencer with a fetch/execute handshake,
// misaligned-target trap redirect and saturating branch statistics.
module pc_branch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IF_ACK,
  input  logic             STALL,
  input  logic             IS_BR,
  input  logic             BR_TAKEN,
  input  logic             IS_JAL,
  input  logic             IS_JALR,
  input  logic [31:0]      IMM,
  input  logic [31:0]      RS1,
  output logic             IF_REQ,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic             RETIRE,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_TRAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             r_retire;
  logic             r_misalign;

  logic [31:0]      w_target;
  logic             w_misaligned;
  logic             w_br_count;

  // Next-PC selection: JALR beats JAL, which beats a taken branch, else sequential.
  always_comb begin
    w_target = r_pc + 32'd4;
    if (IS_JALR) begin
      w_target = (RS1 + IMM) & ~32'h1;
    end else if (IS_JAL || (IS_BR && BR_TAKEN)) begin
      w_target = r_pc + IMM;
    end
  end

  assign w_misaligned = |w_target[1:0];
  // Jumps take precedence, so a branch flag alongside them is not a branch.
  assign w_br_count   = IS_BR & ~IS_JAL & ~IS_JALR;

  // Sequencer FSM, PC register, statistics counters and pulse outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
      r_retire    <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_retire   <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (IF_ACK) r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (!STALL) begin
            if (w_br_count) begin
              if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_ONE;
              if (BR_TAKEN && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
            if (w_misaligned) begin
              r_state <= S_TRAP;
            end else begin
              r_pc     <= w_target;
              r_retire <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
        end
        S_TRAP: begin
          r_pc       <= TRAP_PC;
          r_misalign <= 1'b1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign IF_REQ    = (r_state == S_FETCH);
  assign PC        = r_pc;
  assign PC_PLUS4  = r_pc + 32'd4;
  assign RETIRE    = r_retire;
  assign MISALIGN  = r_misalign;
  assign BR_CNT    = r_br_cnt;
  assign TAKEN_CNT = r_taken_cnt;

endmodule

// File: tb/tb_pc_branch_seq.sv
// Testbench for pc_branch_seq: directed instructions, scoreboard of expected
// retire/trap events checked by an independent monitor. A second instance
// with 4-bit counters shares the stimulus to exercise saturation.
module tb_pc_branch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST, IF_ACK, STALL, IS_BR, BR_TAKEN, IS_JAL, IS_JALR;
  logic [31:0] IMM, RS1;

  logic        IF_REQ, RETIRE, MISALIGN;
  logic [31:0] PC, PC_PLUS4;
  logic [15:0] BR_CNT, TAKEN_CNT;

  logic        IF_REQ4, RETIRE4, MISALIGN4;
  logic [31:0] PC4, PC_PLUS4_4;
  logic [3:0]  BR_CNT4, TAKEN_CNT4;

  pc_branch_seq #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IF_ACK(IF_ACK), .STALL(STALL), .IS_BR(IS_BR),
    .BR_TAKEN(BR_TAKEN), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR), .IMM(IMM), .RS1(RS1),
    .IF_REQ(IF_REQ), .PC(PC), .PC_PLUS4(PC_PLUS4), .RETIRE(RETIRE),
    .MISALIGN(MISALIGN), .BR_CNT(BR_CNT), .TAKEN_CNT(TAKEN_CNT)
  );

  pc_branch_seq #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .IF_ACK(IF_ACK), .STALL(STALL), .IS_BR(IS_BR),
    .BR_TAKEN(BR_TAKEN), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR), .IMM(IMM), .RS1(RS1),
    .IF_REQ(IF_REQ4), .PC(PC4), .PC_PLUS4(PC_PLUS4_4), .RETIRE(RETIRE4),
    .MISALIGN(MISALIGN4), .BR_CNT(BR_CNT4), .TAKEN_CNT(TAKEN_CNT4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    int          br;
    int          tk;
    bit          trap;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  int          m_br, m_tk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: every retire/trap pulse is matched against the next expected event.
  always @(negedge CLK) begin
    if (RETIRE === 1'b1 || MISALIGN === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'b0, RETIRE, MISALIGN}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_pc",        PC,        mon_e.pc);
        chk("ev_pc_plus4",  PC_PLUS4,  mon_e.pc + 32'd4);
        chk("ev_retire",    {31'b0, RETIRE},   {31'b0, !mon_e.trap});
        chk("ev_misalign",  {31'b0, MISALIGN}, {31'b0, mon_e.trap});
        chk("ev_br_cnt",    {16'b0, BR_CNT},    mon_e.br);
        chk("ev_taken_cnt", {16'b0, TAKEN_CNT}, mon_e.tk);
        chk("ev_br_cnt4",   {28'b0, BR_CNT4},    sat4(mon_e.br));
        chk("ev_taken_cnt4",{28'b0, TAKEN_CNT4}, sat4(mon_e.tk));
        chk("ev_pc_w4",     PC4,       mon_e.pc);
      end
    end
  end

  task automatic clear_ctl();
    STALL = 1'b0; IS_BR = 1'b0; BR_TAKEN = 1'b0; IS_JAL = 1'b0; IS_JALR = 1'b0;
    IMM = '0; RS1 = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1; IF_ACK = 1'b0; clear_ctl();
    @(posedge CLK); #1;
    RST = 1'b0;
    m_pc = RST_PC; m_br = 0; m_tk = 0;
    chk("rst_pc",       PC, RST_PC);
    chk("rst_br_cnt",   {16'b0, BR_CNT}, 32'h0);
    chk("rst_taken",    {16'b0, TAKEN_CNT}, 32'h0);
    chk("rst_br_cnt4",  {28'b0, BR_CNT4}, 32'h0);
    chk("rst_retire",   {31'b0, RETIRE}, 32'h0);
    chk("rst_misalign", {31'b0, MISALIGN}, 32'h0);
    chk("rst_if_req",   {31'b0, IF_REQ}, 32'h1);
  endtask

  // Runs one instruction starting just after an edge that left the DUT in FETCH.
  task automatic run_instr(input bit br, input bit tk, input bit jal, input bit jalr,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input int stall_n, input int ack_wait);
    logic [31:0] t;
    exp_t        e;
    for (int i = 0; i < ack_wait; i++) begin
      IF_ACK = 1'b0;
      @(posedge CLK); #1;
      chk("wait_if_req",  {31'b0, IF_REQ}, 32'h1);
      chk("wait_pc",      PC, m_pc);
      chk("wait_retire",  {31'b0, RETIRE}, 32'h0);
    end
    IF_ACK = 1'b1;
    IS_BR = br; BR_TAKEN = tk; IS_JAL = jal; IS_JALR = jalr; IMM = imm; RS1 = rs1;
    STALL = (stall_n > 0);
    @(posedge CLK); #1;
    IF_ACK = 1'b0;
    chk("exec_if_req", {31'b0, IF_REQ}, 32'h0);
    chk("exec_retire", {31'b0, RETIRE}, 32'h0);
    for (int i = 0; i < stall_n; i++) begin
      @(posedge CLK); #1;
      chk("stall_pc",     PC, m_pc);
      chk("stall_retire", {31'b0, RETIRE}, 32'h0);
      chk("stall_if_req", {31'b0, IF_REQ}, 32'h0);
    end
    STALL = 1'b0;
    if (jalr)                  t = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jal || (br && tk)) t = m_pc + imm;
    else                       t = m_pc + 32'd4;
    if (br && !jal && !jalr) begin
      m_br++;
      if (tk) m_tk++;
    end
    if (t[1:0] != 2'b00) begin
      e.pc = TRP_PC; e.br = m_br; e.tk = m_tk; e.trap = 1'b1;
      sb.push_back(e);
      @(posedge CLK); #1;
      clear_ctl();
      chk("trap_pc_hold", PC, m_pc);
      chk("trap_no_retire", {31'b0, RETIRE}, 32'h0);
      @(posedge CLK); #1;
      m_pc = TRP_PC;
    end else begin
      e.pc = t; e.br = m_br; e.tk = m_tk; e.trap = 1'b0;
      sb.push_back(e);
      @(posedge CLK); #1;
      clear_ctl();
      m_pc = t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; IF_ACK = 1'b0; clear_ctl();
    do_reset();

    // sequential stepping with immediate acknowledge
    for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    // JAL to 0x40, then taken / not-taken branch back by 8
    run_instr(0, 0, 1, 0, 32'h30, 32'h0, 0, 0);
    run_instr(1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0);
    run_instr(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0);
    // JALR misaligned trap, counted branch trap, JALR bit0 cleared
    run_instr(0, 0, 0, 1, 32'h2, 32'h1001, 0, 0);
    run_instr(1, 1, 0, 0, 32'h2, 32'h0, 0, 0);
    run_instr(0, 0, 0, 1, 32'h3, 32'h1001, 0, 0);
    // priority: JALR over JAL over branch, counters untouched
    run_instr(1, 1, 1, 1, 32'h10, 32'h2000, 0, 0);
    run_instr(1, 1, 1, 0, 32'h8, 32'h0, 0, 0);
    // stall in EXEC, then withheld acknowledge
    run_instr(0, 0, 0, 0, 32'h0, 32'h0, 3, 0);
    run_instr(0, 0, 0, 1, 32'hFFFF_FFF0, 32'h3000, 0, 5);

    // reset while waiting in FETCH
    IF_ACK = 1'b0;
    @(posedge CLK); #1;
    do_reset();

    // reset while in TRAP, after a counted misaligned branch
    IF_ACK = 1'b1; IS_BR = 1'b1; BR_TAKEN = 1'b1; IMM = 32'h2;
    @(posedge CLK); #1;
    IF_ACK = 1'b0;
    @(posedge CLK); #1;
    clear_ctl();
    chk("trap_br_cnt", {16'b0, BR_CNT}, 32'h1);
    chk("trap_no_misalign_yet", {31'b0, MISALIGN}, 32'h0);
    do_reset();

    // saturation on the 4-bit instance
    for (int i = 0; i < 17; i++) run_instr(1, 1, 0, 0, 32'h4, 32'h0, 0, 0);
    // wrap-around both ways
    run_instr(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 0, 0);
    run_instr(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    run_instr(0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
